// File: rtl/multicycle_cpu_core_if.sv
// Shared instruction/data memory port of the multicycle core.
// Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata stable until the cycle mem_ack is high;
// the transfer completes in that cycle (ack may coincide with req); ack while req is low means nothing.
interface multicycle_cpu_core_if #(
    parameter int WIDTH = 16
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle TSC core: 4-register datapath plus IF/ID/EX/MEM/WB/HALT control FSM
// sharing one memory port for fetches, loads and stores.
module multicycle_cpu_core #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    multicycle_cpu_core_if.master        mem,
    output logic [WIDTH-1:0]             output_port,
    output logic [WIDTH-1:0]             num_inst,
    output logic                         is_halted,
    output logic [2:0]                   state_dbg
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_BGZ = 4'd2, OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6, OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8, OP_JMP = 4'd9, OP_JAL = 4'd10, OP_R = 4'd15;
    localparam logic [5:0] F_ADD = 6'd0, F_SUB = 6'd1, F_AND = 6'd2, F_ORR = 6'd3;
    localparam logic [5:0] F_NOT = 6'd4, F_TCP = 6'd5, F_SHL = 6'd6, F_SHR = 6'd7;
    localparam logic [5:0] F_JPR = 6'd25, F_JRL = 6'd26, F_WWD = 6'd28, F_HLT = 6'd29;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_next;
    logic [15:0]      ir;
    logic [WIDTH-1:0] pc, a, b, alu_out, mdr, alu_res;
    logic [WIDTH-1:0] rf [4];

    logic [3:0]       op;
    logic [5:0]       func;
    logic [1:0]       rs, rt, rd;
    logic [7:0]       imm8;
    logic [WIDTH-1:0] imm_sext, imm_zext, lhi_val, j_target;
    logic             is_r, is_hlt, alu_wb, is_ls, is_branch, taken, retire;

    assign op       = ir[15:12];
    assign func     = ir[5:0];
    assign rs       = ir[11:10];
    assign rt       = ir[9:8];
    assign rd       = ir[7:6];
    assign imm8     = ir[7:0];
    assign imm_sext = WIDTH'($signed(imm8));
    assign imm_zext = WIDTH'(imm8);
    assign lhi_val  = WIDTH'({imm8, 8'h00});
    assign j_target = {pc[WIDTH-1:12], ir[11:0]};

    assign is_r      = (op == OP_R);
    assign is_hlt    = is_r && (func == F_HLT);
    assign alu_wb    = (is_r && (func[5:3] == 3'b000)) || (op == OP_ADI) || (op == OP_ORI) || (op == OP_LHI);
    assign is_ls     = (op == OP_LWD) || (op == OP_SWD);
    assign is_branch = (op == OP_BNE) || (op == OP_BEQ) || (op == OP_BGZ) || (op == OP_BLZ);
    assign state_dbg = state;

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BNE:  taken = (a != b);
            OP_BEQ:  taken = (a == b);
            OP_BGZ:  taken = ($signed(a) > 0);
            OP_BLZ:  taken = a[WIDTH-1];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADI, OP_LWD, OP_SWD: alu_res = a + imm_sext;
            OP_ORI:                 alu_res = a | imm_zext;
            OP_LHI:                 alu_res = lhi_val;
            OP_R: begin
                case (func)
                    F_ADD:   alu_res = a + b;
                    F_SUB:   alu_res = a - b;
                    F_AND:   alu_res = a & b;
                    F_ORR:   alu_res = a | b;
                    F_NOT:   alu_res = ~a;
                    F_TCP:   alu_res = (~a) + ONE;
                    F_SHL:   alu_res = {a[WIDTH-2:0], 1'b0};
                    F_SHR:   alu_res = {a[WIDTH-1], a[WIDTH-1:1]};
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IF;
        else       state <= state_next;
    end

    // Anything that is neither a write-back ALU op nor a load/store retires in EX, NOPs included.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_IF:  if (mem.mem_ack) state_next = S_ID;
            S_ID: begin
                state_next = is_hlt ? S_HALT : S_EX;
                retire     = is_hlt;
            end
            S_EX: begin
                if (alu_wb)     state_next = S_WB;
                else if (is_ls) state_next = S_MEM;
                else begin
                    state_next = S_IF;
                    retire     = 1'b1;
                end
            end
            S_MEM: begin
                if (mem.mem_ack) begin
                    state_next = (op == OP_SWD) ? S_IF : S_WB;
                    retire     = (op == OP_SWD);
                end
            end
            S_WB: begin
                state_next = S_IF;
                retire     = 1'b1;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IF;
        endcase
    end

    // Gated by reset so the port is idle for the whole reset pulse, not just from the next edge.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (!reset) begin
            if (state == S_IF) begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = pc;
            end else if (state == S_MEM) begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = (op == OP_SWD);
                mem.mem_addr  = alu_out;
                mem.mem_wdata = b;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            ir          <= '0;
            a           <= '0;
            b           <= '0;
            alu_out     <= '0;
            mdr         <= '0;
            output_port <= '0;
            num_inst    <= '0;
            is_halted   <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            if (retire) num_inst <= num_inst + ONE;
            case (state)
                S_IF: begin
                    if (mem.mem_ack) begin
                        ir <= mem.mem_rdata[15:0];
                        pc <= pc + ONE;
                    end
                end
                S_ID: begin
                    a <= rf[rs];
                    b <= rf[rt];
                    if (is_hlt) is_halted <= 1'b1;
                end
                S_EX: begin
                    alu_out <= alu_res;
                    // pc already points past this instruction, which is also the link value.
                    if (is_branch && taken) pc <= pc + imm_sext;
                    if (op == OP_JMP) pc <= j_target;
                    if (op == OP_JAL) begin
                        pc    <= j_target;
                        rf[2] <= pc;
                    end
                    if (is_r && (func == F_JPR)) pc <= a;
                    if (is_r && (func == F_JRL)) begin
                        pc    <= a;
                        rf[2] <= pc;
                    end
                    if (is_r && (func == F_WWD)) output_port <= a;
                end
                S_MEM: begin
                    if (mem.mem_ack && (op == OP_LWD)) mdr <= mem.mem_rdata;
                end
                S_WB: begin
                    rf[is_r ? rd : rt] <= (op == OP_LWD) ? mdr : alu_out;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core: a 16-bit core with a configurable wait-state
// memory model and a 32-bit core with a non-zero reset PC.
module tb_multicycle_cpu_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    multicycle_cpu_core_if #(.WIDTH(16)) bus_a();
    multicycle_cpu_core_if #(.WIDTH(32)) bus_b();

    logic [15:0] out_a, ninst_a;
    logic        halt_a;
    logic [2:0]  st_a;
    logic [31:0] out_b, ninst_b;
    logic        halt_b;
    logic [2:0]  st_b;

    multicycle_cpu_core #(.WIDTH(16), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .reset(rst_a), .mem(bus_a),
        .output_port(out_a), .num_inst(ninst_a), .is_halted(halt_a), .state_dbg(st_a)
    );

    multicycle_cpu_core #(.WIDTH(32), .RESET_PC(32'h0000_0100)) dut_b (
        .clk(clk), .reset(rst_b), .mem(bus_b),
        .output_port(out_b), .num_inst(ninst_b), .is_halted(halt_b), .state_dbg(st_b)
    );

    // ---------------- memory models ----------------
    logic [15:0] mem_a [256];
    logic [31:0] mem_b [512];
    int   wait_n    = 0;
    logic stall_wr  = 1'b0;
    logic ack_force = 1'b0;
    int   wcnt      = 0;
    int   wr_cnt_a  = 0;

    always_comb begin
        bus_a.mem_ack   = ack_force || (bus_a.mem_req && !(bus_a.mem_we && stall_wr) && (wcnt == wait_n));
        bus_a.mem_rdata = mem_a[bus_a.mem_addr[7:0]];
        bus_b.mem_ack   = bus_b.mem_req;
        bus_b.mem_rdata = mem_b[bus_b.mem_addr[8:0]];
    end

    always @(posedge clk) begin
        if (rst_a || !bus_a.mem_req || bus_a.mem_ack) wcnt <= 0;
        else                                          wcnt <= wcnt + 1;
        if (bus_a.mem_req && bus_a.mem_ack && bus_a.mem_we) wr_cnt_a <= wr_cnt_a + 1;
    end

    // ---------------- observers ----------------
    logic [31:0] fetch_a[$];
    logic [31:0] fetch_b[$];
    logic        prev_pend = 1'b0;
    logic        prev_we   = 1'b0;
    logic [15:0] prev_addr = '0;
    int          hold_viol = 0;

    always @(negedge clk) begin
        if (rst_a) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend && (!bus_a.mem_req || bus_a.mem_addr != prev_addr || bus_a.mem_we != prev_we))
                hold_viol++;
            prev_pend = bus_a.mem_req && !bus_a.mem_ack;
            prev_addr = bus_a.mem_addr;
            prev_we   = bus_a.mem_we;
            if (st_a == 3'd0 && bus_a.mem_req && bus_a.mem_ack) fetch_a.push_back(32'(bus_a.mem_addr));
        end
        if (!rst_b && st_b == 3'd0 && bus_b.mem_req && bus_b.mem_ack) fetch_b.push_back(bus_b.mem_addr);
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    int          cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic check_fetch_a(input int base);
        check_eq("fetch_count", 32'(fetch_a.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < fetch_a.size()) check_eq("fetch_addr", fetch_a[base + i], exp_q[i]);
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [15:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {op[3:0], rs[1:0], rt[1:0], imm[7:0]};
    endfunction

    function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int func);
        return {4'hF, rs[1:0], rt[1:0], rd[1:0], func[5:0]};
    endfunction

    function automatic logic [15:0] enc_j(input int op, input int tgt);
        return {op[3:0], tgt[11:0]};
    endfunction

    localparam logic [15:0] HLT = 16'hF01D;

    task automatic hold_reset_a();
        rst_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) mem_a[i] = HLT;
    endtask

    task automatic release_a();
        @(negedge clk);
        rst_a = 1'b0;
        cyc   = 0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int base;
        int wbase;
        for (int i = 0; i < 512; i++) mem_b[i] = 32'(HLT);

        // Smoke program, zero-wait memory, including reset state.
        hold_reset_a();
        mem_a[0] = enc_i(6, 0, 0, 1);
        mem_a[1] = enc_i(4, 0, 0, 5);
        mem_a[2] = enc_r(0, 0, 0, 28);
        mem_a[3] = HLT;
        #1;
        check_eq("rst_req", 32'(bus_a.mem_req), 32'd0);
        check_eq("rst_we", 32'(bus_a.mem_we), 32'd0);
        check_eq("rst_addr", 32'(bus_a.mem_addr), 32'd0);
        check_eq("rst_out", 32'(out_a), 32'd0);
        check_eq("rst_ninst", 32'(ninst_a), 32'd0);
        check_eq("rst_halt", 32'(halt_a), 32'd0);
        check_eq("rst_state", 32'(st_a), 32'd0);
        base = fetch_a.size();
        release_a();
        run_to(10); check_eq("smoke_out_c10", 32'(out_a), 32'h0000);
        run_to(11); check_eq("smoke_out_c11", 32'(out_a), 32'h0105);
        check_eq("smoke_ninst_c11", 32'(ninst_a), 32'd3);
        run_to(12); check_eq("smoke_halt_c12", 32'(halt_a), 32'd0);
        run_to(13); check_eq("smoke_halt_c13", 32'(halt_a), 32'd1);
        check_eq("smoke_ninst_c13", 32'(ninst_a), 32'd4);
        ack_force = 1'b1;
        run_to(18);
        ack_force = 1'b0;
        check_eq("halt_sticky", 32'(halt_a), 32'd1);
        check_eq("halt_ninst", 32'(ninst_a), 32'd4);
        check_eq("halt_req", 32'(bus_a.mem_req), 32'd0);
        check_eq("halt_state", 32'(st_a), 32'd5);
        check_eq("halt_out", 32'(out_a), 32'h0105);
        exp_q.delete();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        check_fetch_a(base);

        // Arithmetic edge cases.
        hold_reset_a();
        mem_a[0]  = enc_i(4, 0, 1, -1);
        mem_a[1]  = enc_r(1, 0, 0, 28);
        mem_a[2]  = enc_i(6, 0, 2, 8'h80);
        mem_a[3]  = enc_r(2, 0, 3, 5);
        mem_a[4]  = enc_r(3, 0, 0, 28);
        mem_a[5]  = enc_r(2, 0, 3, 7);
        mem_a[6]  = enc_r(3, 0, 0, 28);
        mem_a[7]  = enc_i(4, 0, 0, 1);
        mem_a[8]  = enc_r(1, 0, 3, 0);
        mem_a[9]  = enc_r(3, 0, 0, 28);
        mem_a[10] = HLT;
        release_a();
        run_to(7);  check_eq("adi_neg1", 32'(out_a), 32'hFFFF);
        run_to(18); check_eq("tcp_8000", 32'(out_a), 32'h8000);
        run_to(25); check_eq("shr_8000", 32'(out_a), 32'hC000);
        run_to(35); check_eq("pre_add_out", 32'(out_a), 32'hC000);
        run_to(36); check_eq("add_wrap", 32'(out_a), 32'h0000);
        run_to(38); check_eq("arith_halt", 32'(halt_a), 32'd1);
        check_eq("arith_ninst", 32'(ninst_a), 32'd11);

        // Three wait states on every request.
        hold_reset_a();
        wait_n = 3;
        mem_a[0]    = enc_i(7, 0, 1, 8'h20);
        mem_a[1]    = enc_r(1, 0, 0, 28);
        mem_a[2]    = HLT;
        mem_a[8'h20] = 16'h1234;
        base  = fetch_a.size();
        wbase = hold_viol;
        release_a();
        run_to(2);  check_eq("ws_if_req", 32'(bus_a.mem_req), 32'd1);
        check_eq("ws_if_addr", 32'(bus_a.mem_addr), 32'd0);
        run_to(8);  check_eq("ws_mem_req", 32'(bus_a.mem_req), 32'd1);
        check_eq("ws_mem_we", 32'(bus_a.mem_we), 32'd0);
        check_eq("ws_mem_addr", 32'(bus_a.mem_addr), 32'h20);
        run_to(10); check_eq("lwd_ninst_c10", 32'(ninst_a), 32'd0);
        run_to(11); check_eq("lwd_ninst_c11", 32'(ninst_a), 32'd1);
        run_to(16); check_eq("ws_out_c16", 32'(out_a), 32'h0000);
        run_to(17); check_eq("ws_lwd_value", 32'(out_a), 32'h1234);
        run_to(22); check_eq("ws_halt", 32'(halt_a), 32'd1);
        check_eq("ws_ninst", 32'(ninst_a), 32'd3);
        check_eq("ws_hold_viol", 32'(hold_viol - wbase), 32'd0);
        exp_q.delete();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        check_fetch_a(base);
        wait_n = 0;

        // Branches and jumps.
        hold_reset_a();
        mem_a[0]     = enc_j(9, 4);
        mem_a[3]     = enc_i(4, 3, 3, 1);
        mem_a[4]     = enc_i(1, 0, 3, -2);
        mem_a[5]     = enc_j(9, 16);
        mem_a[8'h10] = enc_j(10, 32);
        mem_a[8'h11] = enc_r(2, 0, 0, 28);
        mem_a[8'h20] = enc_r(2, 0, 0, 28);
        mem_a[8'h21] = enc_r(2, 0, 0, 26);
        base = fetch_a.size();
        release_a();
        run_to(22); check_eq("jal_link", 32'(out_a), 32'h0011);
        run_to(28); check_eq("jrl_link", 32'(out_a), 32'h0022);
        run_to(30); check_eq("br_halt", 32'(halt_a), 32'd1);
        check_eq("br_ninst", 32'(ninst_a), 32'd10);
        exp_q.delete();
        exp_q.push_back(0);  exp_q.push_back(4);  exp_q.push_back(3);  exp_q.push_back(4);
        exp_q.push_back(5);  exp_q.push_back(16); exp_q.push_back(32); exp_q.push_back(33);
        exp_q.push_back(17); exp_q.push_back(18);
        check_fetch_a(base);

        // Reset while a store is waiting in MEM.
        hold_reset_a();
        stall_wr = 1'b1;
        mem_a[0] = enc_i(8, 0, 0, 8'h30);
        release_a();
        run_to(4);
        check_eq("swd_req", 32'(bus_a.mem_req), 32'd1);
        check_eq("swd_we", 32'(bus_a.mem_we), 32'd1);
        check_eq("swd_addr", 32'(bus_a.mem_addr), 32'h30);
        wbase = wr_cnt_a;
        #2 rst_a = 1'b1;
        #1;
        check_eq("midrst_req", 32'(bus_a.mem_req), 32'd0);
        check_eq("midrst_we", 32'(bus_a.mem_we), 32'd0);
        check_eq("midrst_addr", 32'(bus_a.mem_addr), 32'd0);
        check_eq("midrst_state", 32'(st_a), 32'd0);
        ack_force = 1'b1;
        repeat (2) @(posedge clk);
        ack_force = 1'b0;
        stall_wr  = 1'b0;
        #1;
        check_eq("midrst_no_write", 32'(wr_cnt_a - wbase), 32'd0);
        base = fetch_a.size();
        release_a();
        run_to(1);
        exp_q.delete();
        exp_q.push_back(0);
        check_fetch_a(base);
        check_eq("midrst_ninst", 32'(ninst_a), 32'd0);

        // 32-bit build with RESET_PC = 0x100.
        rst_a = 1'b1;
        mem_b[9'h100] = 32'(enc_i(4, 0, 1, 8'h80));
        mem_b[9'h101] = 32'(enc_r(1, 0, 0, 28));
        mem_b[9'h102] = 32'(HLT);
        #1;
        check_eq("w32_rst_req", 32'(bus_b.mem_req), 32'd0);
        check_eq("w32_rst_ninst", ninst_b, 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        cyc   = 0;
        run_to(7); check_eq("w32_adi_sext", out_b, 32'hFFFF_FF80);
        run_to(9); check_eq("w32_halt", 32'(halt_b), 32'd1);
        check_eq("w32_ninst", ninst_b, 32'd3);
        check_eq("w32_fetch_count", 32'(fetch_b.size()), 32'd3);
        if (fetch_b.size() > 0) check_eq("w32_first_fetch", fetch_b[0], 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
